d_fsld_seq: RTL



---
 rtl/d_fsld_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/d_fsld_seq.sv
`default_nettype none
// ============================================================================
//  Module   : d_fsld_seq
//  Purpose  : First-load (FSLD) sequencer. Routes the gi stream to the kernel
//             writer, then to the bias writer, and pulses done at the end.
//  Option   : define FSLD_BIAS_EN to include the bias-load phase.
//  Revision : 1.0  initial release
// ============================================================================
module d_fsld_seq #(
    parameter logic [15:0] KER_WORDS     = 16'd2304,
    parameter logic [15:0] BIAS_WORDS    = 16'd64,
    parameter int          CNT_BITS      = 16,
    parameter int          MAST_FSM_BITS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fsld_start,
    input  logic                     empty_n_from_gi,
    input  logic                     read_for_gi,
    output logic                     ker_write_en,
    output logic                     bias_write_enable,
    output logic [MAST_FSM_BITS-1:0] fsld_current_state,
    output logic                     fsld_busy,
    output logic                     fsld_done,
    output logic [CNT_BITS-1:0]      beat_cnt,
    output logic                     err_stray
);

    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_KER  = 3'd1,
        FS_BIAS = 3'd2,
        FS_IF   = 3'd3,
        FS_DONE = 3'd4
    } fs_state_e;

    localparam logic [CNT_BITS-1:0] c_KER_LAST = CNT_BITS'(KER_WORDS - 16'd1);

`ifdef FSLD_BIAS_EN
    localparam logic [CNT_BITS-1:0] c_BIAS_LAST = CNT_BITS'(BIAS_WORDS - 16'd1);
    localparam fs_state_e           c_AFTER_KER = FS_BIAS;
`else
    localparam fs_state_e           c_AFTER_KER = FS_DONE;
    // BIAS_WORDS is kept on the interface but has no function in this build
    logic w_unused_bias;
    assign w_unused_bias = ^BIAS_WORDS;
`endif

    fs_state_e           state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q,   cnt_d;
    logic                err_q,   err_d;
    logic                w_beat;

    assign w_beat = empty_n_from_gi & read_for_gi;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FS_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            FS_IDLE: begin
                // An accepted start takes priority over a coincident stray beat
                if (fsld_start) begin
                    state_d = FS_KER;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else if (w_beat) begin
                    err_d = 1'b1;
                end
            end
            FS_KER: begin
                if (w_beat) begin
                    if (cnt_q == c_KER_LAST) begin
                        state_d = c_AFTER_KER;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
            end
`ifdef FSLD_BIAS_EN
            FS_BIAS: begin
                if (w_beat) begin
                    if (cnt_q == c_BIAS_LAST) begin
                        state_d = FS_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
            end
`endif
            FS_DONE: begin
                state_d = FS_IDLE;
                if (w_beat) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = FS_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign ker_write_en       = (state_q == FS_KER);
`ifdef FSLD_BIAS_EN
    assign bias_write_enable  = (state_q == FS_BIAS);
`else
    assign bias_write_enable  = 1'b0;
`endif
    assign fsld_busy          = ker_write_en | bias_write_enable;
    assign fsld_done          = (state_q == FS_DONE);
    assign fsld_current_state = MAST_FSM_BITS'(state_q);
    assign beat_cnt           = cnt_q;
    assign err_stray          = err_q;

endmodule
`default_nettype wire
